// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-client round-robin arbiter onto the memory controller's system command port.
// Optional command watchdog is compiled in with `define ARB_TIMEOUT_EN.
module mem_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       we_sys,
  output logic       cmd_valid_sys,
  output logic [7:0] addr_sys,
  inout  wire  [7:0] data_sys,
  input  logic       ready_sys,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic          last_grant, last_grant_d;
  logic          winner, winner_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          cmd_valid_d, we_sys_d;
  logic [AW-1:0] addr_sys_d;
  logic          ack0_d, ack1_d;
  logic [DW-1:0] rdata0_d, rdata1_d;
  logic [DW-1:0] rdata_new_c;
  logic          busy_d, timeout_err_d;
  logic          grant_c;
  logic          abort_c;

  // Ties go to the client that did not win last time.
  assign grant_c = (req0 && req1) ? ~last_grant : req1;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] to_cnt, to_cnt_d;

  // ready_sys on the final allowed cycle still completes normally.
  assign abort_c = (state == ISSUE) && !ready_sys && (to_cnt == TO_LAST);

  always_comb begin
    to_cnt_d = to_cnt;
    if (state == IDLE) begin
      to_cnt_d = 8'd0;
    end else if (state == ISSUE) begin
      to_cnt_d = to_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= 8'd0;
    end else begin
      to_cnt <= to_cnt_d;
    end
  end
`else
  // Timeout length has no effect while the watchdog is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
  assign abort_c = 1'b0;
`endif

  assign rdata_new_c = ready_sys ? data_sys : 8'hFF;

  // Next-state and next-output decode.
  always_comb begin
    state_d       = state;
    last_grant_d  = last_grant;
    winner_d      = winner;
    wdata_d       = wdata_q;
    cmd_valid_d   = 1'b0;
    we_sys_d      = we_sys;
    addr_sys_d    = addr_sys;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata0_d      = rdata0;
    rdata1_d      = rdata1;
    timeout_err_d = timeout_err | abort_c;

    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = ISSUE;
          last_grant_d = grant_c;
          winner_d     = grant_c;
          cmd_valid_d  = 1'b1;
          we_sys_d     = grant_c ? we1 : we0;
          addr_sys_d   = grant_c ? addr1 : addr0;
          wdata_d      = grant_c ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        if (ready_sys || abort_c) begin
          state_d  = DONE;
          we_sys_d = 1'b0;
          ack0_d   = ~winner;
          ack1_d   = winner;
          if (!we_sys) begin
            if (winner) begin
              rdata1_d = rdata_new_c;
            end else begin
              rdata0_d = rdata_new_c;
            end
          end
        end else begin
          cmd_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      winner        <= 1'b0;
      wdata_q       <= '0;
      cmd_valid_sys <= 1'b0;
      we_sys        <= 1'b0;
      addr_sys      <= '0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_d;
      last_grant    <= last_grant_d;
      winner        <= winner_d;
      wdata_q       <= wdata_d;
      cmd_valid_sys <= cmd_valid_d;
      we_sys        <= we_sys_d;
      addr_sys      <= addr_sys_d;
      ack0          <= ack0_d;
      ack1          <= ack1_d;
      rdata0        <= rdata0_d;
      rdata1        <= rdata1_d;
      busy          <= busy_d;
      timeout_err   <= timeout_err_d;
    end
  end

  // Bus is driven only while a write is outstanding.
  assign data_sys = ((state == ISSUE) && we_sys) ? wdata_q : {DW{1'bz}};

endmodule
